// File: rtl/fifo_rd_stream.sv
// FIFO read-side controller: issues rd_en while downstream has room, absorbs the
// one-cycle read latency in a 2-entry skid buffer and emits a framed valid/ready stream.

module fifo_rd_stream_chk (
   input logic       clk_i,
   input logic       rst_n_i,
   input logic [1:0] occ,
   input logic       inflight
);
   // Buffered plus in-flight words can never exceed the two buffer slots.
   occ_bound_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      ({1'b0, occ} + {2'b00, inflight}) <= 3'd2);
endmodule

module fifo_rd_stream #(
   parameter int WIDTH     = 8,
   parameter int BURST_LEN = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 enable_i,
   input  logic                 empty_i,
   input  logic                 rd_error_i,
   input  logic [WIDTH-1:0]     rdata_i,
   output logic                 rd_en_o,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
   output logic [WIDTH-1:0]     m_data_o,
   output logic                 m_last_o,
   output logic                 err_o,
   output logic [CNT_WIDTH-1:0] word_cnt_o
);
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

   logic [WIDTH-1:0]     buf_r [2];
   logic                 head_r;
   logic [1:0]           occ_r;
   logic                 inflight_r;
   logic [BEAT_W-1:0]    beat_r;
   logic                 err_r;
   logic [CNT_WIDTH-1:0] word_cnt_r;

   logic                 pop_s;
   logic                 cap_s;
   logic                 tail_s;
   logic [2:0]           demand_s;
   logic [1:0]           occ_nxt_s;

   // Read issue, capture qualification and next occupancy.
   always_comb begin
      pop_s     = (occ_r != 2'd0) & m_ready_i;
      cap_s     = inflight_r & ~rd_error_i;
      // A capture only happens with occ <= 1, so the tail is head or its twin.
      tail_s    = head_r ^ occ_r[0];
      demand_s  = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
      occ_nxt_s = occ_r + {1'b0, cap_s} - {1'b0, pop_s};
      rd_en_o   = rst_n_i & enable_i & ~empty_i & (demand_s < 3'd2);
   end

   // Skid buffer, framing counter, delivered-word counter and sticky error.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         buf_r[0]   <= {WIDTH{1'b0}};
         buf_r[1]   <= {WIDTH{1'b0}};
         head_r     <= 1'b0;
         occ_r      <= 2'd0;
         inflight_r <= 1'b0;
         beat_r     <= {BEAT_W{1'b0}};
         err_r      <= 1'b0;
         word_cnt_r <= {CNT_WIDTH{1'b0}};
      end else begin
         inflight_r <= rd_en_o;
         occ_r      <= occ_nxt_s;
         if (cap_s) begin
            buf_r[tail_s] <= rdata_i;
         end
         if (pop_s) begin
            head_r     <= ~head_r;
            word_cnt_r <= word_cnt_r + CNT_WIDTH'(1);
            beat_r     <= (beat_r == BEAT_LAST) ? {BEAT_W{1'b0}} : beat_r + BEAT_W'(1);
         end
         if (inflight_r & rd_error_i) begin
            err_r <= 1'b1;
         end
      end
   end

   assign m_valid_o  = (occ_r != 2'd0);
   assign m_data_o   = buf_r[head_r];
   assign m_last_o   = m_valid_o & (beat_r == BEAT_LAST);
   assign err_o      = err_r;
   assign word_cnt_o = word_cnt_r;

   fifo_rd_stream_chk u_chk (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .occ      (occ_r),
      .inflight (inflight_r)
   );
endmodule
